text_vram_writer: RTL

//  Write-side producer for the text-mode VRAM scanned by the HDMI text pixel logic.

---
 rtl/text_vram_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/text_vram_writer.sv
// Text-mode VRAM write producer: turns an ASCII/control byte stream into byte-enabled
// writes on a 32-bit packed VRAM port (4 chars/word) and tracks the cursor.
// Optional feature: define TEXT_WRITER_AUTOCLEAR_EN to blank each newly entered row.
module text_vram_writer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic [7:0]  in_data,
  input  logic        in_inv,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        vram_we,
  output logic [9:0]  vram_addr,
  output logic [3:0]  vram_be,
  output logic [31:0] vram_wdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam int unsigned Words    = COLS * ROWS / 4;
  localparam int unsigned RowWords = COLS / 4;

`ifdef TEXT_WRITER_AUTOCLEAR_EN
  localparam bit AutoClr = 1'b1;
`else
  localparam bit AutoClr = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StClearRow, StClearAll} state_t;

  state_t      r_state, w_state_next;
  logic        r_we;
  logic [9:0]  r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [6:0]  r_col;
  logic [4:0]  r_row;
  logic [9:0]  r_cnt;   // next clear word address
  logic [9:0]  r_end;   // last clear word address

  logic [6:0]  w_code;
  logic        w_fire;
  logic        w_printable;
  logic        w_wrap;
  logic        w_row_adv;
  logic        w_clr_done;
  logic [11:0] w_idx;
  logic [11:0] w_bs_idx;
  logic [4:0]  w_row_next;
  logic [9:0]  w_row_base;
  logic        w_unused_bit7;

  assign w_code        = in_data[6:0];
  assign w_unused_bit7 = in_data[7];
  assign w_fire        = in_valid && (r_state == StIdle);
  assign w_printable   = (w_code >= 7'h20) && (w_code <= 7'h7E);
  assign w_wrap        = (r_col == 7'(COLS - 1));
  assign w_row_adv     = (w_printable && w_wrap) || (w_code == 7'h0A);
  assign w_clr_done    = (r_cnt == r_end);
  assign w_idx         = 12'(r_row * COLS + r_col);
  assign w_bs_idx      = w_idx - 12'd1;
  assign w_row_next    = (r_row == 5'(ROWS - 1)) ? 5'd0 : r_row + 5'd1;
  assign w_row_base    = 10'(w_row_next * RowWords);

  // State register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= StIdle;
    else              r_state <= w_state_next;
  end

  // Next-state: form feed clears everything, row advance clears the new row if enabled
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_fire && (w_code == 7'h0C))         w_state_next = StClearAll;
        else if (w_fire && AutoClr && w_row_adv) w_state_next = StClearRow;
      end
      StClearRow, StClearAll: begin
        if (w_clr_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake and status outputs; ready is held low while reset is asserted
  always_comb begin
    busy     = (r_state != StIdle);
    in_ready = (r_state == StIdle) && axi_aresetn;
  end

  // Cursor, clear counter and registered write port
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_end   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_fire) begin
        if (w_printable) begin
          r_we    <= 1'b1;
          r_addr  <= w_idx[11:2];
          r_be    <= 4'b0001 << w_idx[1:0];
          r_wdata <= {4{in_inv, w_code}};
          if (w_wrap) begin
            r_col <= '0;
            r_row <= w_row_next;
          end else begin
            r_col <= r_col + 7'd1;
          end
        end else begin
          case (w_code)
            7'h0A: begin
              r_col <= '0;
              r_row <= w_row_next;
            end
            7'h0D: r_col <= '0;
            7'h08: begin
              if (r_col != 7'd0) begin
                r_col   <= r_col - 7'd1;
                r_we    <= 1'b1;
                r_addr  <= w_bs_idx[11:2];
                r_be    <= 4'b0001 << w_bs_idx[1:0];
                r_wdata <= {4{CLEAR_CHAR}};
              end
            end
            7'h0C: begin
              r_cnt <= '0;
              r_end <= 10'(Words - 1);
            end
            default: ;
          endcase
        end
        if (AutoClr && w_row_adv) begin
          r_cnt <= w_row_base;
          r_end <= w_row_base + 10'(RowWords - 1);
        end
      end else if (r_state != StIdle) begin
        r_we    <= 1'b1;
        r_addr  <= r_cnt;
        r_be    <= 4'hF;
        r_wdata <= {4{CLEAR_CHAR}};
        r_cnt   <= r_cnt + 10'd1;
        // Home the cursor as the full-screen clear finishes
        if (w_clr_done && (r_state == StClearAll)) begin
          r_col <= '0;
          r_row <= '0;
        end
      end
    end
  end

  assign vram_we    = r_we;
  assign vram_addr  = r_addr;
  assign vram_be    = r_be;
  assign vram_wdata = r_wdata;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule
